// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder and the
// address/data register units that feed it.
package mem_pkg;

   // Default word-address and data widths for the CPU memory path.
   localparam int unsigned MEM_ADDR_W = 9;
   localparam int unsigned MEM_DATA_W = 32;

   // Responder sequencing states.
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE,
      HOLD
   } state_t;

   // Captured operation type.
   typedef enum logic {
      OP_READ,
      OP_WRITE
   } op_t;

endpackage

// File: rtl/mem_array.sv
// Word array with synchronous write and registered read. The read register
// holds its value until the next read, so it doubles as the responder's rdata.
module mem_array #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage write; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port; only updates on a read so it holds the last result.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a read or write request from the address
// and data registers, waits WAIT_STATES cycles (0..15), performs the access
// and pulses mem_done. One transaction is issued per strobe assertion.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = MEM_ADDR_W,
   parameter int unsigned DATA_W      = MEM_DATA_W,
   parameter int unsigned WAIT_STATES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_done,
   output logic              busy,
   output logic              err
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
   localparam bit         NO_WAIT  = (WAIT_STATES == 0);

   state_t            state_q;
   op_t               op_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // Array access is issued on the edge that enters DONE.
   logic              go_done;
   op_t               acc_op;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

   // Pick the access operands: live inputs on a zero-wait capture, else the captured ones.
   always_comb begin
      go_done   = 1'b0;
      acc_op    = op_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      case (state_q)
         IDLE: begin
            acc_op    = write ? OP_WRITE : OP_READ;
            acc_addr  = addr;
            acc_wdata = wdata;
            go_done   = (read ^ write) && NO_WAIT;
         end
         ACCESS: begin
            go_done = (cnt_q == 4'd0);
         end
         default: begin
            go_done = 1'b0;
         end
      endcase
   end

   mem_array #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .INIT_FILE(INIT_FILE)
   ) u_array (
      .clk  (clk),
      .clr  (clr),
      .we   (go_done && (acc_op == OP_WRITE)),
      .re   (go_done && (acc_op == OP_READ)),
      .addr (acc_addr),
      .wdata(acc_wdata),
      .rdata(rdata)
   );

   // Sequencer with registered handshake outputs.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         op_q     <= OP_READ;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_done <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_done <= 1'b0;
         err      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (read && write) begin
                  err     <= 1'b1;
                  busy    <= 1'b1;
                  state_q <= HOLD;
               end else if (read || write) begin
                  op_q    <= write ? OP_WRITE : OP_READ;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt_q   <= WAIT_CNT;
                  busy    <= 1'b1;
                  if (NO_WAIT) begin
                     mem_done <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == 4'd0) begin
                  mem_done <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               if (read || write) begin
                  state_q <= HOLD;
               end else begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            HOLD: begin
               // Wait for both strobes to drop so a held strobe cannot re-trigger.
               if (!read && !write) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 1 wait state for the
// main vector table, one with 3 wait states for the mid-transaction reset.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        clr [2];
   logic        rd [2];
   logic        wr [2];
   logic [8:0]  ad [2];
   logic [31:0] wd [2];
   logic [31:0] rdata_o [2];
   logic        done_o [2];
   logic        busy_o [2];
   logic        err_o [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_responder #(.WAIT_STATES(1)) u_dut1 (
      .clk     (clk),
      .clr     (clr[0]),
      .addr    (ad[0]),
      .wdata   (wd[0]),
      .read    (rd[0]),
      .write   (wr[0]),
      .rdata   (rdata_o[0]),
      .mem_done(done_o[0]),
      .busy    (busy_o[0]),
      .err     (err_o[0])
   );

   mem_responder #(.WAIT_STATES(3)) u_dut3 (
      .clk     (clk),
      .clr     (clr[1]),
      .addr    (ad[1]),
      .wdata   (wd[1]),
      .read    (rd[1]),
      .write   (wr[1]),
      .rdata   (rdata_o[1]),
      .mem_done(done_o[1]),
      .busy    (busy_o[1]),
      .err     (err_o[1])
   );

   typedef struct {
      int          sel;
      logic        r;
      logic        w;
      logic [8:0]  a;
      logic [31:0] d;
      int          hold;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Apply one request for 'hold' edges, release it, wait for idle and check the handshake.
   task automatic run_txn(input int s, input logic r, input logic w, input logic [8:0] a,
                          input logic [31:0] d, input int hold, input logic [31:0] exp_rdata,
                          input string tag);
      int          done_cnt   = 0;
      int          err_cnt    = 0;
      int          done_idx   = -1;
      int          err_idx    = -1;
      logic [31:0] rd_at_done = '0;
      logic        busy_drop  = 1'b0;
      int          exp_idx    = (s == 0) ? 2 : 4;
      logic        legal      = r ^ w;
      rd[s] = r;
      wr[s] = w;
      ad[s] = a;
      wd[s] = d;
      for (int i = 0; i < 40; i++) begin
         if (i == hold) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
         end
         if (i >= hold && !busy_o[s]) break;
         @(posedge clk);
         #1;
         if (done_o[s]) begin
            done_cnt++;
            done_idx   = i;
            rd_at_done = rdata_o[s];
         end
         if (err_o[s]) begin
            err_cnt++;
            err_idx = i;
         end
         if (i < hold && !busy_o[s]) busy_drop = 1'b1;
      end
      check({tag, " done count"}, done_cnt, legal ? 1 : 0);
      if (legal) check({tag, " done latency"}, done_idx, exp_idx);
      check({tag, " err count"}, err_cnt, legal ? 0 : 1);
      if (!legal) check({tag, " err cycle"}, err_idx, 0);
      check({tag, " busy while held"}, busy_drop, 1'b0);
      check({tag, " busy at end"}, busy_o[s], 1'b0);
      if (legal && r) check({tag, " rdata at done"}, rd_at_done, exp_rdata);
      check({tag, " rdata final"}, rdata_o[s], exp_rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{0, 1'b0, 1'b1, 9'h1A5, 32'hDEADBEEF, 6, 32'h0000_0000};
      vecs[1]  = '{0, 1'b1, 1'b0, 9'h1A5, 32'h0000_0000, 1, 32'hDEADBEEF};
      vecs[2]  = '{0, 1'b0, 1'b1, 9'h000, 32'h0000_0001, 1, 32'hDEADBEEF};
      vecs[3]  = '{0, 1'b0, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 1, 32'hDEADBEEF};
      vecs[4]  = '{0, 1'b1, 1'b0, 9'h000, 32'h0000_0000, 1, 32'h0000_0001};
      vecs[5]  = '{0, 1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 1, 32'hFFFF_FFFF};
      vecs[6]  = '{0, 1'b0, 1'b1, 9'h010, 32'hA5A5_0010, 1, 32'hFFFF_FFFF};
      vecs[7]  = '{0, 1'b1, 1'b0, 9'h010, 32'h0000_0000, 8, 32'hA5A5_0010};
      vecs[8]  = '{0, 1'b1, 1'b1, 9'h010, 32'h0BAD_BAD0, 3, 32'hA5A5_0010};
      vecs[9]  = '{0, 1'b1, 1'b0, 9'h010, 32'h0000_0000, 1, 32'hA5A5_0010};
      vecs[10] = '{0, 1'b1, 1'b0, 9'h1A5, 32'h0000_0000, 1, 32'hDEADBEEF};

      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b0;
         rd[s]  = 1'b0;
         wr[s]  = 1'b0;
         ad[s]  = '0;
         wd[s]  = '0;
      end

      // Reset, then idle with no strobes.
      #12;
      clr[0] = 1'b1;
      clr[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("idle%0d rdata", i), rdata_o[0], 32'h0);
         check($sformatf("idle%0d mem_done", i), done_o[0], 1'b0);
         check($sformatf("idle%0d busy", i), busy_o[0], 1'b0);
         check($sformatf("idle%0d err", i), err_o[0], 1'b0);
      end

      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i].sel, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold,
                 vecs[i].exp_rdata, $sformatf("v%0d", i));
      end

      // Reset during the wait states of a write on the 3-wait-state instance.
      run_txn(1, 1'b0, 1'b1, 9'h042, 32'h1234_5678, 1, 32'h0, "r3 setup wr");
      run_txn(1, 1'b1, 1'b0, 9'h042, 32'h0, 1, 32'h1234_5678, "r3 setup rd");
      wr[1] = 1'b1;
      ad[1] = 9'h042;
      wd[1] = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("r3 busy in access", busy_o[1], 1'b1);
      clr[1] = 1'b0;
      #1;
      check("r3 busy in reset", busy_o[1], 1'b0);
      check("r3 rdata in reset", rdata_o[1], 32'h0);
      check("r3 done in reset", done_o[1], 1'b0);
      check("r3 err in reset", err_o[1], 1'b0);
      wr[1] = 1'b0;
      @(posedge clk);
      #1;
      clr[1] = 1'b1;
      @(posedge clk);
      #1;
      check("r3 idle after reset", busy_o[1], 1'b0);
      run_txn(1, 1'b1, 1'b0, 9'h042, 32'h0, 1, 32'h1234_5678, "r3 after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
